seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_if.sv | 26 ++
 rtl/seg_scan_driver.sv | 85 ++++++++
 tb/tb_seg_scan_driver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Digit inputs and multiplexed 7-segment outputs of the scan driver.
// master drives digits/controls, slave is the driver itself.
interface seg_scan_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       lzb_en;
  logic       display_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output digit0, digit1, digit2, digit3,
    output lzb_en, display_en,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  digit0, digit1, digit2, digit3,
    input  lzb_en, display_en,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver, "SS.hh" format,
// with per-slot anti-ghost blanking and frame-coherent snapshots.
module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 26000,
  parameter int BLANK_CYCLES = 260
) (
  input logic      clk,
  input logic      reset,
  seg_scan_if.slave bus
);

  localparam int CW = $clog2(DIGIT_CYCLES);

  typedef enum logic {
    BLANK,
    DRIVE
  } phase_t;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    shadow [4];
  phase_t        phase;
  logic          wrap;
  logic          snap;
  logic          dark;
  logic [3:0]    cur;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    phase = (cnt < CW'(BLANK_CYCLES)) ? BLANK : DRIVE;
    wrap  = (cnt == CW'(DIGIT_CYCLES - 1));
    snap  = wrap && (idx == 2'd3);
    cur   = shadow[idx];
    // a leading zero in the tens-of-seconds slot keeps the whole slot dark
    dark  = (phase == BLANK) || !bus.display_en ||
            ((idx == 2'd3) && bus.lzb_en && (cur == 4'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      bus.an         <= 4'hF;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx + 2'd1;
      if (snap) begin
        shadow[0] <= bus.digit0;
        shadow[1] <= bus.digit1;
        shadow[2] <= bus.digit2;
        shadow[3] <= bus.digit3;
      end
      bus.frame_tick <= snap;
      if (dark) begin
        bus.an  <= 4'hF;
        bus.seg <= 7'h7F;
        bus.dp  <= 1'b1;
      end else begin
        bus.an  <= ~(4'b0001 << idx);
        bus.seg <= decode(cur);
        bus.dp  <= (idx != 2'd2);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGIT_CYCLES=8, BLANK_CYCLES=2).
// Stimulus queues one expected record per slot; a monitor summarises each slot window.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic reset;

  seg_scan_if bus();

  seg_scan_driver #(
    .DIGIT_CYCLES(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] mask;
    logic [7:0] ft;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   slot_no = 0;
  int   win_no = 0;

  int         mcnt;
  int         pos;
  logic       seen;
  logic       bad;
  logic [3:0] a_an;
  logic [6:0] a_seg;
  logic       a_dp;
  logic [7:0] a_mask;
  logic [7:0] a_ft;
  exp_t       e;

  task automatic clear_acc();
    seen   = 1'b0;
    bad    = 1'b0;
    a_an   = 4'hF;
    a_seg  = 7'h7F;
    a_dp   = 1'b1;
    a_mask = 8'h00;
    a_ft   = 8'h00;
  endtask

  // window of 8 edges per slot; bit k of mask = edge k+1 of the slot drove
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      mcnt = 0;
      clear_acc();
    end else begin
      mcnt++;
      pos = (mcnt - 1) % 8;
      if (bus.an != 4'hF) begin
        if (!seen) begin
          a_an  = bus.an;
          a_seg = bus.seg;
          a_dp  = bus.dp;
          seen  = 1'b1;
        end else if (bus.an != a_an || bus.seg != a_seg || bus.dp != a_dp) begin
          bad = 1'b1;
        end
        a_mask[pos] = 1'b1;
      end else if (bus.seg != 7'h7F || bus.dp != 1'b1) begin
        bad = 1'b1;
      end
      if (bus.frame_tick) a_ft[pos] = 1'b1;
      if (pos == 7) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL win%0d: no expectation queued", win_no);
        end else begin
          e = q.pop_front();
          if (a_an != e.an || a_seg != e.seg || a_dp != e.dp ||
              a_mask != e.mask || a_ft != e.ft || bad) begin
            fails++;
            $display("FAIL win%0d: got an=%h seg=%h dp=%b mask=%h ft=%h bad=%b, want an=%h seg=%h dp=%b mask=%h ft=%h",
                     win_no, a_an, a_seg, a_dp, a_mask, a_ft, bad,
                     e.an, e.seg, e.dp, e.mask, e.ft);
          end
        end
        win_no++;
        clear_acc();
      end
    end
  end

  task automatic push(input logic [3:0] an, input logic [6:0] seg,
                      input logic dp, input logic [7:0] mask);
    exp_t x;
    x.an   = an;
    x.seg  = seg;
    x.dp   = dp;
    x.mask = mask;
    x.ft   = (slot_no % 4 == 3) ? 8'h80 : 8'h00;
    q.push_back(x);
    slot_no++;
  endtask

  task automatic slot(input logic [3:0] an, input logic [6:0] seg,
                      input logic dp, input logic [7:0] mask);
    push(an, seg, dp, mask);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic off_slots(input int n);
    for (int i = 0; i < n; i++) slot(4'hF, 7'h7F, 1'b1, 8'h00);
  endtask

  task automatic chk_dark(input string name);
    tests++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 ||
        bus.frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL %s: got an=%h seg=%h dp=%b ft=%b, want an=f seg=7f dp=1 ft=0",
               name, bus.an, bus.seg, bus.dp, bus.frame_tick);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    bus.digit0     = 4'd4;
    bus.digit1     = 4'd3;
    bus.digit2     = 4'd2;
    bus.digit3     = 4'd1;
    bus.lzb_en     = 1'b1;
    bus.display_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_dark("reset_hold");
    #1 reset = 1'b0;

    // first frame shows cleared shadows, " 0.00"
    slot(4'hE, 7'h40, 1'b1, 8'hFC);
    slot(4'hD, 7'h40, 1'b1, 8'hFC);
    slot(4'hB, 7'h40, 1'b0, 8'hFC);
    slot(4'hF, 7'h7F, 1'b1, 8'h00);
    bus.lzb_en = 1'b0;

    // basic scan 12.34, inputs change mid-frame without tearing
    slot(4'hE, 7'h19, 1'b1, 8'hFC);
    bus.digit0 = 4'd9;
    bus.digit3 = 4'd5;
    slot(4'hD, 7'h30, 1'b1, 8'hFC);
    slot(4'hB, 7'h24, 1'b0, 8'hFC);
    slot(4'h7, 7'h79, 1'b1, 8'hFC);

    bus.digit3 = 4'd0;
    bus.digit1 = 4'hC;
    slot(4'hE, 7'h10, 1'b1, 8'hFC);
    slot(4'hD, 7'h30, 1'b1, 8'hFC);
    slot(4'hB, 7'h24, 1'b0, 8'hFC);
    slot(4'h7, 7'h12, 1'b1, 8'hFC);

    // zero tens digit shown without blanking, invalid code as dash
    slot(4'hE, 7'h10, 1'b1, 8'hFC);
    slot(4'hD, 7'h3F, 1'b1, 8'hFC);
    slot(4'hB, 7'h24, 1'b0, 8'hFC);
    slot(4'h7, 7'h40, 1'b1, 8'hFC);

    // blanking on, display_en dropped mid-slot
    bus.lzb_en = 1'b1;
    slot(4'hE, 7'h10, 1'b1, 8'hFC);
    push(4'hD, 7'h3F, 1'b1, 8'h0C);
    repeat (4) @(posedge clk);
    #1 bus.display_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.display_en = 1'b1;
    slot(4'hB, 7'h24, 1'b0, 8'hFC);
    slot(4'hF, 7'h7F, 1'b1, 8'h00);

    // three dark frames, frame_tick keeps running
    bus.display_en = 1'b0;
    off_slots(12);
    bus.display_en = 1'b1;
    bus.lzb_en     = 1'b0;

    slot(4'hE, 7'h10, 1'b1, 8'hFC);
    slot(4'hD, 7'h3F, 1'b1, 8'hFC);

    // reset during the idx=2 driven phase
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_dark("reset_async");
    bus.digit0 = 4'd7;
    bus.digit1 = 4'd7;
    bus.digit2 = 4'd7;
    bus.digit3 = 4'd7;
    repeat (2) @(negedge clk);
    chk_dark("reset_held");
    #1 reset = 1'b0;
    slot_no = 0;

    slot(4'hE, 7'h40, 1'b1, 8'hFC);
    slot(4'hD, 7'h40, 1'b1, 8'hFC);
    slot(4'hB, 7'h40, 1'b0, 8'hFC);
    slot(4'h7, 7'h40, 1'b1, 8'hFC);
    slot(4'hE, 7'h78, 1'b1, 8'hFC);
    slot(4'hD, 7'h78, 1'b1, 8'hFC);
    slot(4'hB, 7'h78, 1'b0, 8'hFC);
    slot(4'h7, 7'h78, 1'b1, 8'hFC);

    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
